// File: rtl/alu_issue_if.sv
// rtl/alu_issue_if.sv - ID-side and ALU-side handshake bundle for the ALU issue stage
interface alu_issue_if #(
    parameter int DW = 32
);
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_alu_op;
    logic [5:0]    in_funct;
    logic [5:0]    in_opcode;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] data1;
    logic [DW-1:0] data2;
    logic [3:0]    ctrl_sig;
    logic          illegal;

    // Environment side: drives ID fields and EX ready, observes the issued op
    modport master (
        output flush, in_valid, in_alu_op, in_funct, in_opcode, in_a, in_b, out_ready,
        input  in_ready, out_valid, data1, data2, ctrl_sig, illegal
    );

    // Issue stage side
    modport slave (
        input  flush, in_valid, in_alu_op, in_funct, in_opcode, in_a, in_b, out_ready,
        output in_ready, out_valid, data1, data2, ctrl_sig, illegal
    );
endinterface

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - ALU control decode with a 2-entry skid buffer toward EX
module alu_issue #(
    parameter int DW = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    alu_issue_if.slave   bus
);
    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_OR  = 4'b0001;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_SUB = 4'b0110;
    localparam logic [3:0] C_SLT = 4'b0111;
    localparam logic [3:0] C_NOR = 4'b1100;

    logic [3:0]    dec_ctrl;
    logic          dec_ill;

    logic          main_valid_q, main_valid_d;
    logic [DW-1:0] main_a_q, main_a_d, main_b_q, main_b_d;
    logic [3:0]    main_ctrl_q, main_ctrl_d;
    logic          main_ill_q, main_ill_d;

    logic          skid_valid_q, skid_valid_d;
    logic [DW-1:0] skid_a_q, skid_a_d, skid_b_q, skid_b_d;
    logic [3:0]    skid_ctrl_q, skid_ctrl_d;
    logic          skid_ill_q, skid_ill_d;

    logic          in_ready_q, in_ready_d;
    logic          accept, drain;

    assign accept = bus.in_valid & in_ready_q;
    assign drain  = main_valid_q & bus.out_ready;

    // Translate decoded instruction fields into the ALU control code
    always_comb begin
        dec_ctrl = C_ADD;
        dec_ill  = 1'b0;
        unique case (bus.in_alu_op)
            2'b00: dec_ctrl = C_ADD;
            2'b01: dec_ctrl = C_SUB;
            2'b10: begin
                case (bus.in_funct)
                    6'b100000, 6'b100001: dec_ctrl = C_ADD;
                    6'b100010, 6'b100011: dec_ctrl = C_SUB;
                    6'b100100:            dec_ctrl = C_AND;
                    6'b100101:            dec_ctrl = C_OR;
                    6'b100111:            dec_ctrl = C_NOR;
                    6'b101010:            dec_ctrl = C_SLT;
                    default:              dec_ill  = 1'b1;
                endcase
            end
            default: begin
                case (bus.in_opcode)
                    6'b001000, 6'b001001: dec_ctrl = C_ADD;
                    6'b001100:            dec_ctrl = C_AND;
                    6'b001101:            dec_ctrl = C_OR;
                    6'b001010:            dec_ctrl = C_SLT;
                    default:              dec_ill  = 1'b1;
                endcase
            end
        endcase
    end

    // Next-state for main/skid entries; data fields change only when loaded
    always_comb begin
        main_valid_d = main_valid_q;
        main_a_d     = main_a_q;
        main_b_d     = main_b_q;
        main_ctrl_d  = main_ctrl_q;
        main_ill_d   = main_ill_q;
        skid_valid_d = skid_valid_q;
        skid_a_d     = skid_a_q;
        skid_b_d     = skid_b_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_ill_d   = skid_ill_q;
        if (bus.flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (drain && skid_valid_q) begin
            // in_ready is low while skid is full, so no accept can coincide here
            main_valid_d = 1'b1;
            main_a_d     = skid_a_q;
            main_b_d     = skid_b_q;
            main_ctrl_d  = skid_ctrl_q;
            main_ill_d   = skid_ill_q;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || drain) begin
            main_valid_d = accept;
            if (accept) begin
                main_a_d    = bus.in_a;
                main_b_d    = bus.in_b;
                main_ctrl_d = dec_ctrl;
                main_ill_d  = dec_ill;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_a_d     = bus.in_a;
            skid_b_d     = bus.in_b;
            skid_ctrl_d  = dec_ctrl;
            skid_ill_d   = dec_ill;
        end
    end

    // Ready is registered from the next skid occupancy, keeping out_ready off the in_ready path
    assign in_ready_d = ~skid_valid_d;

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_valid_q <= 1'b0;
            main_a_q     <= '0;
            main_b_q     <= '0;
            main_ctrl_q  <= C_ADD;
            main_ill_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_a_q     <= '0;
            skid_b_q     <= '0;
            skid_ctrl_q  <= C_ADD;
            skid_ill_q   <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_valid_q <= main_valid_d;
            main_a_q     <= main_a_d;
            main_b_q     <= main_b_d;
            main_ctrl_q  <= main_ctrl_d;
            main_ill_q   <= main_ill_d;
            skid_valid_q <= skid_valid_d;
            skid_a_q     <= skid_a_d;
            skid_b_q     <= skid_b_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_ill_q   <= skid_ill_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = main_valid_q;
    assign bus.data1     = main_a_q;
    assign bus.data2     = main_b_q;
    assign bus.ctrl_sig  = main_ctrl_q;
    assign bus.illegal   = main_ill_q;
endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - directed self-checking bench for alu_issue
module tb_alu_issue;
    localparam int DW = 32;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    alu_issue_if #(.DW(DW)) bus ();

    alu_issue #(.DW(DW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn,
                         input logic [5:0] opc, input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.in_valid  = v;
        bus.in_alu_op = op;
        bus.in_funct  = fn;
        bus.in_opcode = opc;
        bus.in_a      = a;
        bus.in_b      = b;
    endtask

    logic [5:0] rfunct [8];
    logic [3:0] rctrl  [8];
    logic [5:0] iopc   [5];
    logic [3:0] ictrl  [5];
    logic       iill   [5];

    initial begin
        checks = 0;
        errors = 0;
        rfunct = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h2A, 6'h27, 6'h21, 6'h23};
        rctrl  = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC, 4'h2, 4'h6};
        iopc   = '{6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h23};
        ictrl  = '{4'h2, 4'h0, 4'h1, 4'h7, 4'h2};
        iill   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        rst = 1'b1;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 2'b00, 6'h00, 6'h00, '0, '0);
        step();
        step();
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_data1", bus.data1, 32'h0);
        chk("rst_data2", bus.data2, 32'h0);
        chk("rst_ctrl", bus.ctrl_sig, 4'b0010);
        chk("rst_illegal", bus.illegal, 1'b0);
        rst = 1'b0;
        step();

        // R-type sweep, back to back
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'b10, rfunct[i], 6'h00, DW'(i + 1), DW'(i + 100));
            step();
            chk("rtype_valid", bus.out_valid, 1'b1);
            chk("rtype_ctrl", bus.ctrl_sig, rctrl[i]);
            chk("rtype_illegal", bus.illegal, 1'b0);
            chk("rtype_data1", bus.data1, DW'(i + 1));
        end
        drive(1'b0, 2'b00, 6'h00, 6'h00, '0, '0);
        step();
        chk("idle_valid", bus.out_valid, 1'b0);
        chk("idle_data_hold", bus.data1, 32'd8);

        // alu_op 00 / 01
        drive(1'b1, 2'b01, 6'h00, 6'h00, 32'd9, 32'd4);
        step();
        chk("sub_ctrl", bus.ctrl_sig, 4'b0110);
        drive(1'b1, 2'b00, 6'h3F, 6'h3F, 32'd9, 32'd4);
        step();
        chk("add_ctrl", bus.ctrl_sig, 4'b0010);
        chk("add_illegal", bus.illegal, 1'b0);

        // Illegal funct
        drive(1'b1, 2'b10, 6'h3F, 6'h00, 32'd5, 32'd7);
        step();
        chk("ill_valid", bus.out_valid, 1'b1);
        chk("ill_ctrl", bus.ctrl_sig, 4'b0010);
        chk("ill_illegal", bus.illegal, 1'b1);
        chk("ill_data1", bus.data1, 32'd5);
        chk("ill_data2", bus.data2, 32'd7);
        drive(1'b0, 2'b00, 6'h00, 6'h00, '0, '0);
        step();

        // Backpressure: A held, B in skid, C waits
        bus.out_ready = 1'b0;
        drive(1'b1, 2'b10, 6'h24, 6'h00, 32'hA, 32'h1A);
        step();
        chk("bp_a_valid", bus.out_valid, 1'b1);
        chk("bp_a_data", bus.data1, 32'hA);
        chk("bp_a_ready", bus.in_ready, 1'b1);
        drive(1'b1, 2'b10, 6'h25, 6'h00, 32'hB, 32'h1B);
        step();
        chk("bp_b_hold", bus.data1, 32'hA);
        chk("bp_b_hold_ctrl", bus.ctrl_sig, 4'b0000);
        chk("bp_b_ready", bus.in_ready, 1'b0);
        drive(1'b1, 2'b10, 6'h2A, 6'h00, 32'hC, 32'h1C);
        step();
        chk("bp_c_hold", bus.data1, 32'hA);
        chk("bp_c_valid", bus.out_valid, 1'b1);
        chk("bp_c_ready", bus.in_ready, 1'b0);
        bus.out_ready = 1'b1;
        step();
        chk("bp_rel_b", bus.data1, 32'hB);
        chk("bp_rel_b_ctrl", bus.ctrl_sig, 4'b0001);
        chk("bp_rel_ready", bus.in_ready, 1'b1);
        step();
        chk("bp_rel_c", bus.data1, 32'hC);
        chk("bp_rel_c_ctrl", bus.ctrl_sig, 4'b0111);
        chk("bp_rel_c_valid", bus.out_valid, 1'b1);
        drive(1'b0, 2'b00, 6'h00, 6'h00, '0, '0);
        step();
        chk("bp_empty", bus.out_valid, 1'b0);

        // Full throughput
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 2'b00, 6'h00, 6'h00, DW'(32'h200 + i), DW'(i));
            step();
            chk("tp_valid", bus.out_valid, 1'b1);
            chk("tp_data1", bus.data1, DW'(32'h200 + i));
            chk("tp_ready", bus.in_ready, 1'b1);
        end
        drive(1'b0, 2'b00, 6'h00, 6'h00, '0, '0);
        step();
        chk("tp_end", bus.out_valid, 1'b0);

        // Flush with main and skid full, input offered
        bus.out_ready = 1'b0;
        drive(1'b1, 2'b00, 6'h00, 6'h00, 32'h300, 32'h0);
        step();
        drive(1'b1, 2'b00, 6'h00, 6'h00, 32'h301, 32'h0);
        step();
        chk("fl_pre_ready", bus.in_ready, 1'b0);
        bus.flush = 1'b1;
        drive(1'b1, 2'b00, 6'h00, 6'h00, 32'h302, 32'h0);
        step();
        chk("fl_valid", bus.out_valid, 1'b0);
        chk("fl_ready", bus.in_ready, 1'b1);
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 2'b00, 6'h00, 6'h00, '0, '0);
        step();
        chk("fl_post1", bus.out_valid, 1'b0);
        step();
        chk("fl_post2", bus.out_valid, 1'b0);

        // Reset mid-stall
        bus.out_ready = 1'b0;
        drive(1'b1, 2'b10, 6'h24, 6'h00, 32'h400, 32'h401);
        step();
        drive(1'b1, 2'b10, 6'h25, 6'h00, 32'h402, 32'h403);
        step();
        rst = 1'b1;
        drive(1'b0, 2'b00, 6'h00, 6'h00, '0, '0);
        step();
        chk("mrst_valid", bus.out_valid, 1'b0);
        chk("mrst_ready", bus.in_ready, 1'b1);
        chk("mrst_data1", bus.data1, 32'h0);
        chk("mrst_data2", bus.data2, 32'h0);
        chk("mrst_ctrl", bus.ctrl_sig, 4'b0010);
        chk("mrst_illegal", bus.illegal, 1'b0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("mrst_after", bus.out_valid, 1'b0);

        // I-type decode
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'b11, 6'h20, iopc[i], DW'(32'h500 + i), 32'h0);
            step();
            chk("itype_valid", bus.out_valid, 1'b1);
            chk("itype_ctrl", bus.ctrl_sig, ictrl[i]);
            chk("itype_illegal", bus.illegal, iill[i]);
            chk("itype_data1", bus.data1, DW'(32'h500 + i));
        end
        drive(1'b0, 2'b00, 6'h00, 6'h00, '0, '0);
        step();
        chk("final_idle", bus.out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
